// File: rtl/alarm_trigger_if.sv
// Alarm trigger control/status bundle: time compare inputs, user requests and ring status.
// master drives the requests and times; slave is the alarm_trigger block.
interface alarm_trigger_if;
  logic       tick;
  logic       enable;
  logic [6:0] cur_hour;
  logic [6:0] cur_min;
  logic [6:0] alarm_hour;
  logic [6:0] alarm_min;
  logic       snooze;
  logic       stop;
  logic       ringing;
  logic       buzzer;
  logic       snoozing;
  logic [1:0] snooze_left;
  logic       alarm_event;

  modport master (
    output tick, enable, cur_hour, cur_min, alarm_hour, alarm_min, snooze, stop,
    input  ringing, buzzer, snoozing, snooze_left, alarm_event
  );

  modport slave (
    input  tick, enable, cur_hour, cur_min, alarm_hour, alarm_min, snooze, stop,
    output ringing, buzzer, snoozing, snooze_left, alarm_event
  );
endinterface

// File: rtl/alarm_trigger.sv
// Alarm clock ring/snooze/dismiss controller; all outputs registered, one clk after the cause.
// No backpressure: requests are single-cycle pulses acted on in the cycle they appear.
module alarm_trigger #(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input logic            clk,
  input logic            clear_n,
  alarm_trigger_if.slave bus
);

  localparam int RING_CW = $clog2(RING_SEC + 1);
  localparam int SNZ_CW  = $clog2(SNOOZE_SEC + 1);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE, DONE} state_t;

  state_t              state_q, state_d;
  logic [RING_CW-1:0]  ring_cnt_q, ring_cnt_d;
  logic [SNZ_CW-1:0]   snz_cnt_q, snz_cnt_d;
  logic [1:0]          left_q, left_d;
  logic                buzz_q, buzz_d;
  logic                event_q, event_d;
  logic                ringing_q, snoozing_q;
  logic                match;

  assign match = bus.enable & (bus.cur_hour == bus.alarm_hour) & (bus.cur_min == bus.alarm_min);

  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    left_d     = left_q;
    buzz_d     = buzz_q;
    event_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (match) begin
          state_d    = RING;
          ring_cnt_d = '0;
          left_d     = 2'(MAX_SNOOZE);
          event_d    = 1'b1;
          buzz_d     = 1'b1;
        end
      end
      RING: begin
        // Request pulses take precedence; a tick in the same cycle is dropped.
        if (!bus.enable) begin
          state_d = IDLE;
        end else if (bus.stop) begin
          state_d = DONE;
        end else if (bus.snooze && (left_q != 2'd0)) begin
          state_d   = SNOOZE;
          left_d    = left_q - 2'd1;
          snz_cnt_d = SNZ_CW'(SNOOZE_SEC);
        end else if (bus.tick) begin
          if (ring_cnt_q == RING_CW'(RING_SEC - 1)) begin
            state_d = DONE;
          end else begin
            ring_cnt_d = ring_cnt_q + 1'b1;
            buzz_d     = ~buzz_q;
          end
        end
      end
      SNOOZE: begin
        if (!bus.enable) begin
          state_d = IDLE;
        end else if (bus.stop) begin
          state_d = DONE;
        end else if (bus.tick) begin
          if (snz_cnt_q == SNZ_CW'(1)) begin
            state_d    = RING;
            ring_cnt_d = '0;
            snz_cnt_d  = '0;
            event_d    = 1'b1;
            buzz_d     = 1'b1;
          end else begin
            snz_cnt_d = snz_cnt_q - 1'b1;
          end
        end
      end
      DONE: begin
        // Hold off until the matched minute passes so the same minute cannot retrigger.
        if (!match) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) begin
      ring_cnt_d = '0;
      snz_cnt_d  = '0;
      left_d     = 2'd0;
    end
    if (state_d != RING) begin
      buzz_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_q    <= IDLE;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      left_q     <= 2'd0;
      buzz_q     <= 1'b0;
      event_q    <= 1'b0;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      left_q     <= left_d;
      buzz_q     <= buzz_d;
      event_q    <= event_d;
      ringing_q  <= (state_d == RING);
      snoozing_q <= (state_d == SNOOZE);
    end
  end

  assign bus.ringing     = ringing_q;
  assign bus.buzzer      = buzz_q;
  assign bus.snoozing    = snoozing_q;
  assign bus.snooze_left = left_q;
  assign bus.alarm_event = event_q;

endmodule

// File: doc/alarm_trigger.md
ALARM_TRIGGER -- requirements
Module: alarm_trigger

Interface
REQ-001 SHALL have parameter RING_SEC, default 60, max ring duration in seconds before auto-stop.
REQ-002 SHALL have parameter SNOOZE_SEC, default 300, snooze interval in seconds.
REQ-003 SHALL have parameter MAX_SNOOZE, default 3, snoozes allowed per alarm event.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-005 SHALL have port clear_n  input  1  reset: one clock; reset is synchronous and active-low.
REQ-006 SHALL have port tick  input  1  one-cycle 1 Hz seconds strobe.
REQ-007 SHALL have port enable  input  1  alarm armed.
REQ-008 SHALL have port cur_hour  input  7  current hour, 0-23, from hour counter out.
REQ-009 SHALL have port cur_min  input  7  current minute, 0-59.
REQ-010 SHALL have port alarm_hour  input  7  alarm hour, 0-23.
REQ-011 SHALL have port alarm_min  input  7  alarm minute, 0-59.
REQ-012 SHALL have port snooze  input  1  snooze request, level-sampled, one-cycle pulse expected.
REQ-013 SHALL have port stop  input  1  dismiss request, one-cycle pulse expected.
REQ-014 SHALL have port ringing  output  1  high in RING.
REQ-015 SHALL have port buzzer  output  1  beep drive, ringing gated with 1 Hz toggle.
REQ-016 SHALL have port snoozing  output  1  high in SNOOZE.
REQ-017 SHALL have port snooze_left  output  2  snoozes remaining in current event.
REQ-018 SHALL have port alarm_event  output  1  one-cycle pulse on every entry to RING.

Function
REQ-019 SHALL define match = enable & (cur_hour==alarm_hour) & (cur_min==alarm_min), full 7-bit compare, evaluated every clk.
REQ-020 SHALL implement FSM states IDLE, RING, SNOOZE, DONE; all outputs registered.
REQ-021 IDLE: match -> RING next cycle, ring second counter := 0, snooze_left := MAX_SNOOZE, alarm_event pulses.
REQ-022 RING: priority per cycle: !enable -> IDLE; stop -> DONE; snooze with snooze_left>0 -> SNOOZE, snooze_left decrements, snooze counter := SNOOZE_SEC; tick with ring counter==RING_SEC-1 -> DONE; else tick increments ring counter.
REQ-023 RING: snooze with snooze_left==0 SHALL be ignored; ringing continues.
REQ-024 buzzer SHALL be 1 on the first cycle of RING and toggle on each tick while in RING; 0 in all other states.
REQ-025 SNOOZE: priority: !enable -> IDLE; stop -> DONE; tick decrements snooze counter; tick with counter==1 -> RING, ring counter := 0, alarm_event pulses, snooze_left unchanged.
REQ-026 SNOOZE re-entry to RING SHALL NOT depend on match.
REQ-027 DONE: stay while match; !match -> IDLE; prevents retrigger within the matched minute.
REQ-028 Simultaneous stop and snooze SHALL act as stop.
REQ-029 tick and stop/snooze in same cycle: stop/snooze wins, tick consumed without counting.
REQ-030 Deasserting enable SHALL cancel from any state to IDLE; re-enable during the matched minute retriggers.
REQ-031 Counters SHALL be wide enough for parameters; no wrap possible in legal operation.

Reset
REQ-032 clear_n==0 at posedge SHALL force IDLE, ringing=0, buzzer=0, snoozing=0, alarm_event=0, snooze_left=0, all counters 0, overriding every other input, including mid-RING/SNOOZE.

Verification
REQ-033 alarm 07:30, enable=1, cur 07:29 -> 07:30 -> ringing=1 and alarm_event 1-cycle pulse one clk later, snooze_left=3.
REQ-034 RING, 60 ticks, no input -> DONE after 60th tick; ringing=0; no retrigger while cur_min=30; IDLE at 07:31.
REQ-035 RING, snooze x3 each followed by 300 ticks -> snooze_left 2,1,0, RING re-entered each time; 4th snooze ignored, ringing stays 1.
REQ-036 RING, stop and snooze same cycle -> DONE, snoozing=0.
REQ-037 SNOOZE with 150 ticks left, enable=0 -> IDLE next cycle, all outputs 0.
REQ-038 clear_n=0 mid-RING with buzzer=1 -> next cycle all outputs 0, state IDLE; release with match still true -> RING again.
